fetch_seq: RTL and testbench
============================

// Module: fetch_seq
// PURPOSE
//   Instruction fetch/sequence controller for the Simple CPU v1; sits directly upstream of
//   the program counter and drives its adrs_in/en_pc load port. Reads the current PC,
//   fetches the instruction over a req/ack memory handshake and holds it in an instruction
//   register. It hands non-branch opcodes to the datapath and computes the next PC:
//   PC+1, or the branch target for JMP/JZ.
// PARAMETERS
//   ADDR_W    8      address width; must match the program counter width
//   INSTR_W   16     instruction width; opcode = ir[INSTR_W-1 -: 4], operand = ir[ADDR_W-1:0]
//   OP_JMP    4'hA   unconditional jump opcode
//   OP_JZ     4'hB   jump-if-zero opcode
//   OP_HALT   4'hF   halt opcode
// PORTS
//   clk        in   1        system clock, rising edge
//   clr        in   1        asynchronous reset, active low
//   run        in   1        level; 1 = sequencer may start or continue fetching
//   pc_adrs    in   ADDR_W   current PC value (program counter adrs_out)
//   mem_req    out  1        instruction read request, level
//   mem_adrs   out  ADDR_W   read address; equals pc_adrs while mem_req=1
//   mem_ack    in   1        read complete; mem_rdata valid in the same cycle
//   mem_rdata  in   INSTR_W  instruction word
//   ir_out     out  INSTR_W  instruction register
//   exec_start out  1        1-cycle pulse: datapath executes ir_out
//   exec_done  in   1        datapath finished the current instruction
//   zero_flag  in   1        datapath zero flag
//   adrs_in    out  ADDR_W   next PC value (to program counter adrs_in)
//   en_pc      out  1        PC load enable (to program counter en_pc)
//   halted     out  1        1 while in HALT
//   busy       out  1        1 in any state except IDLE and HALT
// BEHAVIOUR
//   - Reset (clr=0, asynchronous): state=IDLE. All outputs are 0: mem_req, exec_start,
//     en_pc, halted, busy, ir_out, adrs_in and mem_adrs. The internal branch flag is
//     cleared. An in-flight fetch or execute is abandoned with no completion.
//   - All outputs are registered or decoded from the state register only.
//     No combinational path exists from any input to any output.
//   - IDLE: if run=1, go to FETCH on the next edge.
//   - FETCH: mem_req=1 and mem_adrs=pc_adrs.
//     - mem_req stays high until mem_ack is sampled high.
//     - On ack, mem_rdata is captured into ir_out and the state moves to DECODE; mem_req
//       is 0 from the next cycle.
//     - Zero-wait ack (ack in the first FETCH cycle) is legal and gives a 1-cycle fetch.
//   - DECODE (1 cycle):
//     - opcode==OP_HALT -> HALT.
//     - OP_JMP -> UPDATE with branch flag taken=1.
//     - OP_JZ -> UPDATE with taken=zero_flag, sampled in this cycle.
//     - Any other opcode -> EXEC, and exec_start is pulsed high for the first EXEC cycle only.
//   - EXEC: wait for exec_done=1, then go to UPDATE.
//     exec_done in the same cycle as exec_start is legal.
//   - UPDATE (1 cycle): en_pc=1. adrs_in = taken ? ir_out[ADDR_W-1:0] : pc_adrs+1.
//     - The increment is modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
//     - The PC captures adrs_in at the end of this cycle; the next FETCH uses the new PC.
//     - Next state is FETCH if run=1, otherwise IDLE.
//   - HALT: halted=1 and no further fetches. Leave only via clr.
//   - en_pc is high for exactly one cycle per completed instruction and never in any other state.
//   - Inputs that arrive outside the state that uses them are ignored:
//     mem_ack outside FETCH, exec_done outside EXEC.
//   - run=0 mid-instruction: the current instruction completes, including the PC update,
//     then the sequencer enters IDLE.
//   - Latency for a non-branch instruction: fetch (>=1) + decode 1 + exec (>=1) + update 1 cycles.
// TESTING
//   1. Release clr, run=1, pc=00, ack 2 cycles after req with 16'h1234; exec_done 1 cycle
//      after exec_start -> mem_req high 3 cycles, mem_adrs=00, one exec_start pulse,
//      then en_pc=1 for 1 cycle with adrs_in=8'h01.
//   2. Fetch 16'hA042 (JMP) -> no exec_start; en_pc=1 with adrs_in=8'h42, 2 cycles after ack.
//   3. Fetch 16'hB030 (JZ) at pc=05: with zero_flag=0 -> adrs_in=8'h06;
//      with zero_flag=1 -> adrs_in=8'h30.
//   4. pc=8'hFF, fetch 16'h1000 -> adrs_in=8'h00 (wrap-around).
//   5. Fetch 16'hF000 -> halted=1, busy=0, no en_pc, mem_req stays 0 for 20 cycles.
//      Pulsing clr then run=1 -> fetch resumes at pc_adrs.
//   6. Assert clr while in FETCH with mem_req=1 -> all outputs 0 immediately, before the
//      next clk edge. A late mem_ack after release is ignored. run=0 during EXEC -> one
//      en_pc, then IDLE with mem_req=0.

Source files
------------

// File: rtl/fetch_seq.sv
// Instruction fetch/sequence controller: fetches over req/ack, decodes JMP/JZ/HALT, loads next PC.
// Latency: fetch(>=1) + decode 1 + exec(>=1, non-branch only) + update 1 cycles; outputs registered.
// Backpressure: mem_req held until mem_ack; EXEC held until exec_done; run=0 parks in IDLE after update.
module fetch_seq #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter logic [3:0]  OP_JMP  = 4'hA,
    parameter logic [3:0]  OP_JZ   = 4'hB,
    parameter logic [3:0]  OP_HALT = 4'hF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_adrs,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_adrs,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic               zero_flag,
    output logic [ADDR_W-1:0]  adrs_in,
    output logic               en_pc,
    output logic               halted,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  mem_adrs_q, mem_adrs_d;
    logic [ADDR_W-1:0]  adrs_in_q, adrs_in_d;
    logic               taken_q, taken_d;
    logic               exec_start_q, exec_start_d;
    logic               en_pc_q, en_pc_d;

    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    assign opcode = ir_q[INSTR_W-1 -: 4];
    assign target = ir_q[ADDR_W-1:0];
    assign pc_inc = pc_adrs + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        taken_d      = taken_q;
        mem_adrs_d   = '0;
        exec_start_d = 1'b0;
        en_pc_d      = 1'b0;
        adrs_in_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_FETCH;
                    mem_adrs_d = pc_adrs;
                end
            end
            S_FETCH: begin
                mem_adrs_d = pc_adrs;
                if (mem_ack) begin
                    ir_d       = mem_rdata;
                    state_d    = S_DECODE;
                    mem_adrs_d = '0;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_JMP) begin
                    taken_d = 1'b1;
                    state_d = S_UPDATE;
                end else if (opcode == OP_JZ) begin
                    taken_d = zero_flag;
                    state_d = S_UPDATE;
                end else begin
                    taken_d      = 1'b0;
                    exec_start_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                taken_d = 1'b0;
                if (run) begin
                    // The PC loads adrs_in on this edge, so the new fetch address is adrs_in itself.
                    state_d    = S_FETCH;
                    mem_adrs_d = adrs_in_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_UPDATE) begin
            en_pc_d   = 1'b1;
            adrs_in_d = taken_d ? target : pc_inc;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            mem_adrs_q   <= '0;
            adrs_in_q    <= '0;
            taken_q      <= 1'b0;
            exec_start_q <= 1'b0;
            en_pc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            mem_adrs_q   <= mem_adrs_d;
            adrs_in_q    <= adrs_in_d;
            taken_q      <= taken_d;
            exec_start_q <= exec_start_d;
            en_pc_q      <= en_pc_d;
        end
    end

    assign mem_req    = (state_q == S_FETCH);
    assign mem_adrs   = mem_adrs_q;
    assign ir_out     = ir_q;
    assign exec_start = exec_start_q;
    assign adrs_in    = adrs_in_q;
    assign en_pc      = en_pc_q;
    assign halted     = (state_q == S_HALT);
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: instruction-level reference (memory image + architectural PC) with randomized handshakes.
module tb_fetch_seq;

    logic        clk;
    logic        clr;
    logic        run;
    logic [7:0]  pc;
    logic        mem_req;
    logic [7:0]  mem_adrs;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        exec_start;
    logic        exec_done;
    logic        zero_flag;
    logic [7:0]  adrs_in;
    logic        en_pc;
    logic        halted;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:255];
    logic [7:0]  pc_m;

    fetch_seq dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .pc_adrs    (pc),
        .mem_req    (mem_req),
        .mem_adrs   (mem_adrs),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir_out     (ir_out),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .zero_flag  (zero_flag),
        .adrs_in    (adrs_in),
        .en_pc      (en_pc),
        .halted     (halted),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_req"},   mem_req,    0);
        chk_eq({tag, "_madr"},  mem_adrs,   0);
        chk_eq({tag, "_ir"},    ir_out,     0);
        chk_eq({tag, "_start"}, exec_start, 0);
        chk_eq({tag, "_adrs"},  adrs_in,    0);
        chk_eq({tag, "_enpc"},  en_pc,      0);
        chk_eq({tag, "_halt"},  halted,     0);
        chk_eq({tag, "_busy"},  busy,       0);
    endtask

    // One instruction at the architectural level: fetch mem[pc_m], then either halt or retire with next PC.
    task automatic do_instr(input int ack_dly, input int done_dly, input logic zf,
                            input logic run_after, output logic hit_halt);
        logic [15:0] instr;
        logic [7:0]  nxt;
        logic [3:0]  op;
        int          n;
        int          bad;
        hit_halt = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk_eq("req_seen", mem_req, 1);
        chk_eq("mem_adrs", mem_adrs, pc_m);
        instr = mem[pc_m];
        op    = instr[15:12];
        for (int i = 0; i < ack_dly; i++) begin
            exec_done = 1'($urandom_range(0, 1));
            tick();
            chk_eq("req_hold", mem_req, 1);
        end
        exec_done = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = instr;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        chk_eq("req_drop", mem_req, 0);
        chk_eq("ir_out", ir_out, instr);
        zero_flag = zf;
        run       = run_after;
        if (op == 4'hF) begin
            tick();
            zero_flag = 1'($urandom_range(0, 1));
            chk_eq("halted", halted, 1);
            chk_eq("halt_busy", busy, 0);
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                run       = 1'b1;
                mem_ack   = 1'($urandom_range(0, 1));
                exec_done = 1'($urandom_range(0, 1));
                tick();
                if (mem_req !== 1'b0 || en_pc !== 1'b0 || halted !== 1'b1) bad++;
            end
            mem_ack   = 1'b0;
            exec_done = 1'b0;
            run       = 1'b0;
            chk_eq("halt_quiet", bad, 0);
            hit_halt = 1'b1;
            return;
        end
        nxt = (op == 4'hA || (op == 4'hB && zf)) ? instr[7:0] : pc_m + 8'd1;
        if (op != 4'hA && op != 4'hB) begin
            tick();
            zero_flag = 1'($urandom_range(0, 1));
            chk_eq("exec_start", exec_start, 1);
            for (int i = 0; i < done_dly; i++) begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = 16'($urandom);
                tick();
                chk_eq("exec_pulse", exec_start, 0);
                chk_eq("exec_no_enpc", en_pc, 0);
            end
            mem_ack   = 1'b0;
            exec_done = 1'b1;
            tick();
            exec_done = 1'b0;
        end else begin
            tick();
            zero_flag = 1'($urandom_range(0, 1));
        end
        chk_eq("en_pc", en_pc, 1);
        chk_eq("adrs_in", adrs_in, nxt);
        chk_eq("upd_no_start", exec_start, 0);
        chk_eq("upd_ir", ir_out, instr);
        pc_m = nxt;
        pc   = nxt;
        tick();
        chk_eq("en_pc_once", en_pc, 0);
        chk_eq("next_req", mem_req, run_after);
        if (run_after) chk_eq("next_adrs", mem_adrs, nxt);
        else           chk_eq("idle_busy", busy, 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b0;
        tick();
        clr = 1'b1;
    endtask

    logic       h;
    logic [3:0] op_r;

    initial begin
        clr = 1'b0; run = 1'b0; pc = 8'h00; mem_ack = 1'b0; mem_rdata = '0;
        exec_done = 1'b0; zero_flag = 1'b0; pc_m = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
        #1;
        chk_all_zero("rst");
        tick();
        tick();

        // Basic non-branch, 3-cycle fetch.
        mem[8'h00] = 16'h1234;
        clr = 1'b1; run = 1'b1;
        do_instr(2, 1, 1'b0, 1'b0, h);

        // JMP from PC 01.
        mem[8'h01] = 16'hA042;
        run = 1'b1;
        do_instr(0, 0, 1'b0, 1'b0, h);

        // JZ at PC 05, not taken then taken.
        mem[8'h05] = 16'hB030;
        pc = 8'h05; pc_m = 8'h05; run = 1'b1;
        do_instr(1, 0, 1'b0, 1'b0, h);
        pc = 8'h05; pc_m = 8'h05; run = 1'b1;
        do_instr(0, 0, 1'b1, 1'b0, h);

        // Increment wraps at the top of the address space.
        mem[8'hFF] = 16'h1000;
        pc = 8'hFF; pc_m = 8'hFF; run = 1'b1;
        do_instr(0, 0, 1'b0, 1'b0, h);

        // HALT, then clear and resume.
        mem[8'h10] = 16'hF000;
        pc = 8'h10; pc_m = 8'h10; run = 1'b1;
        do_instr(0, 0, 1'b0, 1'b0, h);
        chk_eq("halt_seen", h, 1);
        mem[8'h20] = 16'h3055;
        pc = 8'h20; pc_m = 8'h20;
        pulse_clr();
        run = 1'b1;
        do_instr(0, 2, 1'b0, 1'b0, h);

        // Asynchronous clear in the middle of a fetch; late ack afterwards is ignored.
        run = 1'b1;
        tick();
        chk_eq("pre_clr_req", mem_req, 1);
        clr = 1'b0;
        #1;
        chk_all_zero("aclr");
        tick();
        run = 1'b0;
        clr = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk_eq("late_ack_ir", ir_out, 0);
        chk_eq("late_ack_req", mem_req, 0);
        chk_eq("late_ack_busy", busy, 0);

        // Randomized programs.
        for (int i = 0; i < 256; i++) begin
            op_r = 4'($urandom_range(0, 15));
            if (op_r == 4'hF && $urandom_range(0, 7) != 0) op_r = 4'h2;
            mem[i] = {op_r, 12'($urandom)};
        end
        pc = 8'($urandom); pc_m = pc;
        pulse_clr();
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic ra;
            ra = ($urandom_range(0, 4) != 0);
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), ra, h);
            if (h) begin
                pc = 8'($urandom); pc_m = pc;
                pulse_clr();
                run = 1'b1;
            end else if (!ra) begin
                tick();
                chk_eq("idle_stays", mem_req, 0);
                run = 1'b1;
            end
        end

        run = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
